// File: rtl/writeback_unit_pkg.sv
// Shared types and defaults for the writeback path.
//   DWIDTH_DEF   default writeback data width
//   REG_W        register index width
//   reg_idx_t    architectural register index
//   wb_entry_t   buffered load result {rd, data} at the default width
package writeback_unit_pkg;

   localparam int DWIDTH_DEF = 32;
   localparam int REG_W      = 5;
   localparam int NUM_REGS   = 32;

   typedef logic [REG_W-1:0] reg_idx_t;

   typedef struct packed {
      reg_idx_t              rd;
      logic [DWIDTH_DEF-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/writeback_unit_fifo.sv
// Circular FIFO holding load results waiting for the register-file write port.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
//   clk, rst          clock, synchronous active-high reset
//   push, push_data   write an entry at the tail (caller guarantees !full)
//   pop               drop the head entry (caller guarantees !empty)
//   head_data         current head entry
//   full, empty       occupancy flags
module wb_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 37
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;

   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_data = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage needs no reset: entries are only read between push and pop.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback stage merging ALU results and buffered load results.
// ALU results have priority and no backpressure; load results queue in a FIFO.
// A starve counter stalls the ALU when a buffered load waits too long.
// A pending-register scoreboard tracks dispatched loads not yet written back.
//   clk, rst                             clock, synchronous active-high reset
//   alu_valid_i/alu_rd_i/alu_data_i      ALU result
//   mem_valid_i/mem_rd_i/mem_data_i      load result, handshake with mem_ready_o
//   pend_set_i/pend_rd_i                 load dispatched, destination pending
//   rs1_i/rs2_i -> rs1_busy_o/rs2_busy_o scoreboard queries (combinational)
//   alu_stall_o                          ALU must not present a result next cycle
//   regwren_o/rd_o/datawb_o              registered register-file write port
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int DWIDTH       = DWIDTH_DEF,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid_i,
   input  logic [4:0]        alu_rd_i,
   input  logic [DWIDTH-1:0] alu_data_i,
   input  logic              mem_valid_i,
   input  logic [4:0]        mem_rd_i,
   input  logic [DWIDTH-1:0] mem_data_i,
   output logic              mem_ready_o,
   input  logic              pend_set_i,
   input  logic [4:0]        pend_rd_i,
   input  logic [4:0]        rs1_i,
   input  logic [4:0]        rs2_i,
   output logic              rs1_busy_o,
   output logic              rs2_busy_o,
   output logic              alu_stall_o,
   output logic              regwren_o,
   output logic [4:0]        rd_o,
   output logic [DWIDTH-1:0] datawb_o
);

   localparam int EW = REG_W + DWIDTH;
   localparam int CW = $clog2(STARVE_LIMIT + 1);

   logic              fifo_push;
   logic              fifo_pop;
   logic              fifo_full;
   logic              fifo_empty;
   logic [EW-1:0]     fifo_head;
   reg_idx_t          head_rd;
   logic [DWIDTH-1:0] head_data;

   logic              wb_sel;
   reg_idx_t          sel_rd;
   logic [DWIDTH-1:0] sel_data;

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;
   logic [CW-1:0]       starve_q;

   assign mem_ready_o = !fifo_full && !rst;
   assign fifo_push   = mem_valid_i && mem_ready_o;
   assign fifo_pop    = !rst && !alu_valid_i && !fifo_empty;
   assign head_rd     = fifo_head[EW-1:DWIDTH];
   assign head_data   = fifo_head[DWIDTH-1:0];

   wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data ({mem_rd_i, mem_data_i}),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      wb_sel   = alu_valid_i || fifo_pop;
      sel_rd   = head_rd;
      sel_data = head_data;
      if (alu_valid_i) begin
         sel_rd   = alu_rd_i;
         sel_data = alu_data_i;
      end
   end

   // A selected rd=0 still updates rd_o/datawb_o but never raises the enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         regwren_o <= 1'b0;
         rd_o      <= '0;
         datawb_o  <= '0;
      end else if (wb_sel) begin
         regwren_o <= (sel_rd != '0);
         rd_o      <= sel_rd;
         datawb_o  <= sel_data;
      end else begin
         regwren_o <= 1'b0;
      end
   end

   // Set is applied after clear so a same-register set wins.
   always_comb begin
      pending_d = pending_q;
      if (fifo_pop)   pending_d[head_rd]   = 1'b0;
      if (pend_set_i) pending_d[pend_rd_i] = 1'b1;
      pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) pending_q <= '0;
      else     pending_q <= pending_d;
   end

   assign rs1_busy_o = !rst && (pending_q[rs1_i] ||
                       (pend_set_i && (pend_rd_i == rs1_i) && (rs1_i != '0)));
   assign rs2_busy_o = !rst && (pending_q[rs2_i] ||
                       (pend_set_i && (pend_rd_i == rs2_i) && (rs2_i != '0)));

   always_ff @(posedge clk) begin
      if (rst || fifo_empty || fifo_pop) begin
         starve_q <= '0;
      end else if (starve_q != CW'(STARVE_LIMIT)) begin
         starve_q <= starve_q + 1'b1;
      end
   end

   // The counter holds at the limit until a pop, so the stall clears one
   // cycle after that pop.
   always_ff @(posedge clk) begin
      if (rst) alu_stall_o <= 1'b0;
      else     alu_stall_o <= !fifo_pop && (starve_q == CW'(STARVE_LIMIT));
   end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;
   import writeback_unit_pkg::*;

   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_valid_i;
   logic [4:0]    alu_rd_i;
   logic [DW-1:0] alu_data_i;
   logic          mem_valid_i;
   logic [4:0]    mem_rd_i;
   logic [DW-1:0] mem_data_i;
   logic          mem_ready_o;
   logic          pend_set_i;
   logic [4:0]    pend_rd_i;
   logic [4:0]    rs1_i;
   logic [4:0]    rs2_i;
   logic          rs1_busy_o;
   logic          rs2_busy_o;
   logic          alu_stall_o;
   logic          regwren_o;
   logic [4:0]    rd_o;
   logic [DW-1:0] datawb_o;

   always #5 clk = ~clk;

   writeback_unit #(
      .DWIDTH       (DW),
      .DEPTH        (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid_i (alu_valid_i),
      .alu_rd_i    (alu_rd_i),
      .alu_data_i  (alu_data_i),
      .mem_valid_i (mem_valid_i),
      .mem_rd_i    (mem_rd_i),
      .mem_data_i  (mem_data_i),
      .mem_ready_o (mem_ready_o),
      .pend_set_i  (pend_set_i),
      .pend_rd_i   (pend_rd_i),
      .rs1_i       (rs1_i),
      .rs2_i       (rs2_i),
      .rs1_busy_o  (rs1_busy_o),
      .rs2_busy_o  (rs2_busy_o),
      .alu_stall_o (alu_stall_o),
      .regwren_o   (regwren_o),
      .rd_o        (rd_o),
      .datawb_o    (datawb_o)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: queue of buffered loads, pending bitmap, expected write
   // port, how long the head has waited, and expected stall.
   wb_entry_t     mq[$];
   logic [31:0]   m_pend;
   logic          m_wren;
   reg_idx_t      m_rd;
   logic [DW-1:0] m_data;
   int            m_wait;
   logic          m_stall;
   bit            m_live = 0;

   typedef struct {
      logic av; reg_idx_t ard; logic [31:0] adata;
      logic mv; reg_idx_t mrd; logic [31:0] mdata;
      logic ps; reg_idx_t prd; reg_idx_t r1; reg_idx_t r2;
      logic wren; reg_idx_t rd; logic [31:0] data;
      logic ready; logic b1; logic b2;
   } vec_t;

   vec_t vt[14];

   function automatic vec_t mk(logic av, reg_idx_t ard, logic [31:0] adata,
                               logic mv, reg_idx_t mrd, logic [31:0] mdata,
                               logic ps, reg_idx_t prd, reg_idx_t r1, reg_idx_t r2,
                               logic wren, reg_idx_t rd, logic [31:0] data,
                               logic ready, logic b1, logic b2);
      vec_t v;
      v.av = av; v.ard = ard; v.adata = adata;
      v.mv = mv; v.mrd = mrd; v.mdata = mdata;
      v.ps = ps; v.prd = prd; v.r1 = r1; v.r2 = r2;
      v.wren = wren; v.rd = rd; v.data = data;
      v.ready = ready; v.b1 = b1; v.b2 = b2;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic exp_busy(input reg_idx_t rs);
      if (rst || rs == 5'd0) return 1'b0;
      return m_pend[rs] || (pend_set_i && pend_rd_i == rs);
   endfunction

   task automatic drive(input logic av, input reg_idx_t ard, input logic [31:0] adata,
                        input logic mv, input reg_idx_t mrd, input logic [31:0] mdata,
                        input logic ps, input reg_idx_t prd,
                        input reg_idx_t r1, input reg_idx_t r2);
      alu_valid_i = av; alu_rd_i = ard; alu_data_i = adata;
      mem_valid_i = mv; mem_rd_i = mrd; mem_data_i = mdata;
      pend_set_i  = ps; pend_rd_i = prd;
      rs1_i = r1; rs2_i = r2;
   endtask

   task automatic settle();
      @(negedge clk);
      if (m_live) begin
         chk("regwren", regwren_o, m_wren);
         chk("rd", rd_o, m_rd);
         chk("datawb", datawb_o, m_data);
         chk("mem_ready", mem_ready_o, (rst ? 1'b0 : (mq.size() < DEPTH)));
         chk("alu_stall", alu_stall_o, m_stall);
         chk("rs1_busy", rs1_busy_o, exp_busy(rs1_i));
         chk("rs2_busy", rs2_busy_o, exp_busy(rs2_i));
      end
   endtask

   task automatic advance();
      wb_entry_t e;
      bit popped;
      bit nonempty;
      int pre_size;
      if (rst) begin
         mq.delete();
         m_pend = '0; m_wren = 0; m_rd = '0; m_data = '0;
         m_wait = 0; m_stall = 0; m_live = 1;
      end else begin
         pre_size = mq.size();
         nonempty = (pre_size > 0);
         popped   = !alu_valid_i && nonempty;
         if (alu_valid_i) begin
            m_wren = (alu_rd_i != 0); m_rd = alu_rd_i; m_data = alu_data_i;
         end else if (popped) begin
            e = mq.pop_front();
            m_wren = (e.rd != 0); m_rd = e.rd; m_data = e.data;
            m_pend[e.rd] = 1'b0;
         end else begin
            m_wren = 0;
         end
         if (pend_set_i && pend_rd_i != 0) m_pend[pend_rd_i] = 1'b1;
         m_pend[0] = 1'b0;
         m_stall = (m_wait == LIMIT) && !popped;
         if (nonempty && !popped) m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
         else                     m_wait = 0;
         if (mem_valid_i && pre_size < DEPTH) begin
            e.rd = mem_rd_i; e.data = mem_data_i;
            mq.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic step();
      settle();
      advance();
   endtask

   // Protocol monitor: the ALU must not present a result while stalled.
   always @(negedge clk) begin
      if (!rst && alu_stall_o && alu_valid_i) begin
         errors++;
         $display("FAIL alu_protocol: alu_valid_i=1 while alu_stall_o=1 (t=%0t)", $time);
      end
   end

   initial begin
      vt[0]  = mk(0,0,0,           1,5,32'hDEADBEEF, 0,0, 5,0, 0,0,0,            1,0,0);
      vt[1]  = mk(0,0,0,           0,0,0,            0,0, 5,0, 0,0,0,            1,0,0);
      vt[2]  = mk(0,0,0,           0,0,0,            0,0, 0,0, 1,5,32'hDEADBEEF, 1,0,0);
      vt[3]  = mk(1,3,32'd7,       1,4,32'h44,       0,0, 0,0, 0,5,32'hDEADBEEF, 1,0,0);
      vt[4]  = mk(0,0,0,           0,0,0,            0,0, 0,0, 1,3,32'd7,        1,0,0);
      vt[5]  = mk(0,0,0,           0,0,0,            0,0, 0,0, 1,4,32'h44,       1,0,0);
      vt[6]  = mk(0,0,0,           0,0,0,            1,9, 9,9, 0,4,32'h44,       1,1,1);
      vt[7]  = mk(0,0,0,           0,0,0,            0,0, 9,1, 0,4,32'h44,       1,1,0);
      vt[8]  = mk(0,0,0,           1,9,32'h99,       0,0, 9,0, 0,4,32'h44,       1,1,0);
      vt[9]  = mk(0,0,0,           0,0,0,            1,9, 9,0, 0,4,32'h44,       1,1,0);
      vt[10] = mk(0,0,0,           0,0,0,            0,0, 9,0, 1,9,32'h99,       1,1,0);
      vt[11] = mk(0,0,0,           1,0,32'h1234,     1,0, 0,0, 0,9,32'h99,       1,0,0);
      vt[12] = mk(0,0,0,           0,0,0,            0,0, 0,0, 0,9,32'h99,       1,0,0);
      vt[13] = mk(0,0,0,           0,0,0,            0,0, 0,0, 0,0,32'h1234,     1,0,0);

      rst = 1'b1;
      drive(0,0,0, 0,0,0, 0,0, 0,0);
      @(posedge clk);
      #1;
      advance();
      step();
      rst = 1'b0;

      // Reset values of the registered outputs.
      @(negedge clk);
      chk("reset_regwren", regwren_o, 1'b0);
      chk("reset_rd", rd_o, 5'd0);
      chk("reset_datawb", datawb_o, 32'd0);
      chk("reset_stall", alu_stall_o, 1'b0);
      @(posedge clk);
      #1;

      // Directed table: single load, ALU/load collision, scoreboard set/clear
      // race, rd=0 load and rd=0 pend_set.
      for (int i = 0; i < 14; i++) begin
         drive(vt[i].av, vt[i].ard, vt[i].adata, vt[i].mv, vt[i].mrd, vt[i].mdata,
               vt[i].ps, vt[i].prd, vt[i].r1, vt[i].r2);
         settle();
         chk($sformatf("vec%0d_regwren", i), regwren_o, vt[i].wren);
         chk($sformatf("vec%0d_rd", i), rd_o, vt[i].rd);
         chk($sformatf("vec%0d_datawb", i), datawb_o, vt[i].data);
         chk($sformatf("vec%0d_ready", i), mem_ready_o, vt[i].ready);
         chk($sformatf("vec%0d_rs1_busy", i), rs1_busy_o, vt[i].b1);
         chk($sformatf("vec%0d_rs2_busy", i), rs2_busy_o, vt[i].b2);
         advance();
      end

      // Starvation: fill the FIFO under continuous ALU traffic, stall appears
      // ten cycles after the first push, ALU backs off, head drains.
      for (int k = 0; k < 16; k++) begin
         drive(k < 10, 5'd2, 32'(k), k < 4, 5'(10 + k), 32'hA0 + 32'(k), 0, 0, 0, 0);
         settle();
         chk($sformatf("starve_k%0d_stall", k), alu_stall_o, (k == 10));
         if (k == 4) chk("starve_full_ready", mem_ready_o, 1'b0);
         if (k == 11) begin
            chk("starve_pop_wren", regwren_o, 1'b1);
            chk("starve_pop_rd", rd_o, 5'd10);
            chk("starve_pop_data", datawb_o, 32'hA0);
         end
         advance();
      end

      // Reset with three buffered loads and pending registers.
      for (int k = 0; k < 3; k++) begin
         drive(1, 5'd7, 32'h77, 1, 5'(20 + k), 32'hB0 + 32'(k), 1, 5'(20 + k), 0, 0);
         step();
      end
      rst = 1'b1;
      drive(1, 5'd7, 32'h77, 1, 5'd23, 32'hBB, 1, 5'd23, 5'd20, 5'd23);
      settle();
      chk("rst_ready_during", mem_ready_o, 1'b0);
      advance();
      rst = 1'b0;
      for (int j = 0; j < 5; j++) begin
         drive(0,0,0, 0,0,0, 0,0, 5'd20, (j == 0) ? 5'd9 : 5'd21);
         settle();
         chk($sformatf("post_rst%0d_regwren", j), regwren_o, 1'b0);
         chk($sformatf("post_rst%0d_ready", j), mem_ready_o, 1'b1);
         chk($sformatf("post_rst%0d_rs1_busy", j), rs1_busy_o, 1'b0);
         chk($sformatf("post_rst%0d_rs2_busy", j), rs2_busy_o, 1'b0);
         advance();
      end

      // Randomized traffic against the model, with ALU bursts long enough to
      // starve the FIFO and occasional resets.
      begin
         int burst = 0;
         logic av;
         for (int n = 0; n < 600; n++) begin
            if (burst == 0 && $urandom_range(0, 15) == 0) burst = $urandom_range(6, 20);
            if (burst > 0) burst--;
            av = !m_stall && ((burst > 0) ? 1'b1 : ($urandom_range(0, 2) == 0));
            rst = ($urandom_range(0, 127) == 0);
            drive(av, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
            step();
         end
         rst = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, meaning writeback data width.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning memory-path FIFO entries (power of two).
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 8, meaning the wait cycle count of a non-empty FIFO that triggers ALU stall.
REQ-004 The block SHALL have port clk, input, 1, meaning clock.
REQ-005 The block SHALL have port rst, input, 1, meaning reset: synchronous, active-high.
REQ-006 The block SHALL have ports alu_valid_i, alu_rd_i and alu_data_i: input, 1 / 5 / DWIDTH, meaning the ALU result (no backpressure).
REQ-007 The block SHALL have ports mem_valid_i, mem_rd_i and mem_data_i: input, 1 / 5 / DWIDTH, meaning the load result.
REQ-008 The block SHALL have port mem_ready_o, output, 1, meaning the FIFO can accept.
REQ-009 The block SHALL have ports pend_set_i and pend_rd_i: input, 1 / 5, meaning a load is dispatched and its destination becomes pending.
REQ-010 The block SHALL have ports rs1_i and rs2_i: input, 5, meaning the scoreboard query addresses.
REQ-011 The block SHALL have ports rs1_busy_o and rs2_busy_o: output, 1, meaning the queried register is pending.
REQ-012 The block SHALL have port alu_stall_o, output, 1, meaning the upstream ALU shall not present a result next cycle.
REQ-013 The block SHALL have ports regwren_o, rd_o and datawb_o: output, 1 / 5 / DWIDTH, meaning the register file write port.

Function
REQ-014 The mem handshake SHALL complete on a cycle with mem_valid_i && mem_ready_o; the (rd, data) pair pushes to the FIFO tail.
REQ-015 mem_ready_o SHALL be !full && !rst; a pop and push in the same cycle SHALL be allowed only when not full before the cycle.
REQ-016 Arbitration per cycle SHALL be: if alu_valid_i, select ALU; else if FIFO non-empty, pop head and select it; else select none.
REQ-017 The write port SHALL be registered: the selection in cycle N drives regwren_o, rd_o and datawb_o in cycle N+1; with no selection, regwren_o=0 and rd_o/datawb_o hold.
REQ-018 A selected entry with rd=0 SHALL produce regwren_o=0 and SHALL still be consumed (FIFO pops).
REQ-019 The starve counter SHALL increment each cycle the FIFO is non-empty and not popped, reset to 0 on pop or empty, and saturate at STARVE_LIMIT.
REQ-020 alu_stall_o SHALL be registered, asserting the cycle after the counter reaches STARVE_LIMIT and deasserting the cycle after the next pop.
REQ-021 alu_valid_i=1 while alu_stall_o=1 SHALL be a protocol violation; the block still gives the ALU priority, and a bench assertion SHALL flag it.
REQ-022 Scoreboard: pending[pend_rd_i] SHALL set on pend_set_i; pending[rd] SHALL clear when a FIFO entry is popped for write; ALU writes SHALL NOT clear.
REQ-023 On a simultaneous set and clear of the same register, set SHALL win.
REQ-024 pending[0] SHALL always be 0; pend_set_i with pend_rd_i=0 SHALL be ignored.
REQ-025 rsX_busy_o SHALL be combinational: pending[rsX_i], including same-cycle pend_set_i forwarding (pend_set_i && pend_rd_i==rsX_i && rsX_i!=0).

Reset
REQ-026 On rst, the FIFO SHALL empty, all pending bits SHALL clear, and the starve counter SHALL be set to 0.
REQ-027 On rst, regwren_o, rd_o, datawb_o and alu_stall_o SHALL all be 0.
REQ-028 Reset mid-operation SHALL discard buffered loads with no writeback issued, and SHALL ignore all inputs in that cycle.

Structure
REQ-029 DWIDTH default, the 5-bit register index type and the wb_entry_t struct {rd, data} SHALL reside in the shared package constants.svh.
REQ-030 The FIFO SHALL be one sub-module, wb_fifo (parameter DEPTH, push/pop/full/empty, circular pointers with a wrap bit).
REQ-031 Scoreboard, arbiter and starve logic SHALL live in writeback_unit; RTL size SHALL be 150-300 lines total.

Verification
REQ-032 Scenario: mem push rd=5 data=0xDEAD_BEEF, no ALU -> regwren_o=1, rd_o=5, datawb_o=0xDEADBEEF two cycles after handshake.
REQ-033 Scenario: ALU rd=3 data=7 and mem push rd=4 in the same cycle -> rd 3 written in cycle N+1, rd 4 in cycle N+2.
REQ-034 Scenario: 4 mem pushes while ALU valid continuously -> mem_ready_o=0 after 4th; after 8 waiting cycles alu_stall_o=1; ALU drops -> head popped, alu_stall_o falls the cycle after.
REQ-035 Scenario: pend_set rd=9, query rs1=9 -> busy same cycle; pop of rd=9 with same-cycle pend_set rd=9 -> remains busy.
REQ-036 Scenario: mem push rd=0 data=0x1234 -> FIFO empties, regwren_o stays 0; pend_set rd=0 -> rs1_busy_o(rs1=0)=0.
REQ-037 Scenario: 3 entries buffered, rst pulsed 1 cycle -> no writes follow, mem_ready_o=0 during rst and 1 after, and all busy outputs are 0.
